// File: rtl/acs_sched.sv
// Sequencing controller for the Viterbi BMU/ACS datapath: issues one symbol at a time,
// holds path metrics and survivors between recursions, and reports the best end state.
module acs_sched #(
    parameter int unsigned FRAME_LEN = 8,
    parameter logic [3:0]  PM_INIT   = 4'hF,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_bit_pair,
    output logic       dp_refresh,
    output logic       dp_valid,
    output logic [1:0] dp_bit_pair,
    output logic [2:0] dp_wp,
    output logic [3:0] pm_00,
    output logic [3:0] pm_01,
    output logic [3:0] pm_10,
    output logic [3:0] pm_11,
    output logic [7:0] sb_00,
    output logic [7:0] sb_01,
    output logic [7:0] sb_10,
    output logic [7:0] sb_11,
    input  logic       dp_valid_ret,
    input  logic [2:0] dp_wp_ret,
    input  logic [3:0] new_pm_00,
    input  logic [3:0] new_pm_01,
    input  logic [3:0] new_pm_10,
    input  logic [3:0] new_pm_11,
    input  logic [7:0] upd_sb_00,
    input  logic [7:0] upd_sb_01,
    input  logic [7:0] upd_sb_10,
    input  logic [7:0] upd_sb_11,
    output logic       frame_done,
    output logic [1:0] best_state,
    output logic [3:0] best_metric,
    output logic       err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t     r_state;
    logic [2:0] r_sym_cnt;
    logic [7:0] r_timer;

    logic       w_norm;
    logic [3:0] w_pm_00, w_pm_01, w_pm_10, w_pm_11;
    logic [5:0] w_best;
    logic       w_last;
    logic       w_timeout;

    // Metrics only grow, so drop the shared MSB once every state has reached it.
    function automatic logic [3:0] norm(input logic [3:0] m, input logic clr);
        return clr ? {1'b0, m[2:0]} : m;
    endfunction

    function automatic logic [5:0] pick_min(input logic [3:0] m0, input logic [3:0] m1,
                                            input logic [3:0] m2, input logic [3:0] m3);
        logic [1:0] s;
        logic [3:0] m;
        s = 2'd0;
        m = m0;
        if (m1 < m) begin s = 2'd1; m = m1; end
        if (m2 < m) begin s = 2'd2; m = m2; end
        if (m3 < m) begin s = 2'd3; m = m3; end
        return {s, m};
    endfunction

    assign w_norm    = new_pm_00[3] & new_pm_01[3] & new_pm_10[3] & new_pm_11[3];
    assign w_pm_00   = norm(new_pm_00, w_norm);
    assign w_pm_01   = norm(new_pm_01, w_norm);
    assign w_pm_10   = norm(new_pm_10, w_norm);
    assign w_pm_11   = norm(new_pm_11, w_norm);
    assign w_best    = pick_min(w_pm_00, w_pm_01, w_pm_10, w_pm_11);
    assign w_last    = (r_sym_cnt == 3'(FRAME_LEN - 1));
    assign w_timeout = (r_timer == 8'(TIMEOUT - 1));
    assign in_ready  = (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sym_cnt   <= 3'd0;
            r_timer     <= 8'd0;
            dp_valid    <= 1'b0;
            dp_refresh  <= 1'b0;
            dp_bit_pair <= 2'd0;
            dp_wp       <= 3'd0;
            pm_00       <= 4'd0;
            pm_01       <= 4'd0;
            pm_10       <= 4'd0;
            pm_11       <= 4'd0;
            sb_00       <= 8'd0;
            sb_01       <= 8'd0;
            sb_10       <= 8'd0;
            sb_11       <= 8'd0;
            frame_done  <= 1'b0;
            best_state  <= 2'd0;
            best_metric <= 4'd0;
            err         <= 1'b0;
        end else begin
            dp_valid   <= 1'b0;
            dp_refresh <= 1'b0;
            frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        dp_valid    <= 1'b1;
                        dp_refresh  <= (r_sym_cnt == 3'd0);
                        dp_bit_pair <= in_bit_pair;
                        dp_wp       <= r_sym_cnt;
                        // Frame start: state 00 is the known encoder start state.
                        if (r_sym_cnt == 3'd0) begin
                            pm_00 <= 4'd0;
                            pm_01 <= PM_INIT;
                            pm_10 <= PM_INIT;
                            pm_11 <= PM_INIT;
                            sb_00 <= 8'd0;
                            sb_01 <= 8'd0;
                            sb_10 <= 8'd0;
                            sb_11 <= 8'd0;
                        end
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_timer <= 8'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (dp_valid_ret) begin
                        pm_00 <= w_pm_00;
                        pm_01 <= w_pm_01;
                        pm_10 <= w_pm_10;
                        pm_11 <= w_pm_11;
                        sb_00 <= upd_sb_00;
                        sb_01 <= upd_sb_01;
                        sb_10 <= upd_sb_10;
                        sb_11 <= upd_sb_11;
                        if (dp_wp_ret != dp_wp) err <= 1'b1;
                        r_sym_cnt <= r_sym_cnt + 3'd1;
                        if (w_last) begin
                            frame_done  <= 1'b1;
                            best_state  <= w_best[5:4];
                            best_metric <= w_best[3:0];
                            r_state     <= S_DONE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (w_timeout) begin
                        err       <= 1'b1;
                        r_sym_cnt <= 3'd0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                S_DONE: begin
                    r_sym_cnt <= 3'd0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
